rfile_track_avg: RTL and testbench

- Downstream stage of the RSSI localisation engine. Consumes each position fix (xt, yt, single-cycle out_valid pulse) and keeps a sliding window of the last DEPTH accepted fixes.
- Publishes a rounded moving-average position and rejects implausible jumps.
- Re-acquires (relocks) after a run of consecutive outliers, so a genuine target move is followed rather than filtered forever.

---
 rtl/rfile_track_avg.sv | 226 ++++++++++++++++++++++
 tb/tb_rfile_track_avg.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rfile_track_avg.sv
// rfile_track_avg
// Moving-average tracker for the position fixes coming out of the RSSI
// localiser. Keeps the last DEPTH accepted fixes in a circular window,
// publishes the rounded mean one cycle after each window update, rejects
// fixes that jump too far from the published mean, and re-acquires after
// OUTLIER_MAX consecutive rejects.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   clear      synchronous flush of the window (wins over in_valid)
//   in_valid   fix strobe
//   xt, yt     fix coordinates, sampled when in_valid=1
//   avg_x/y    published rounded average (registered)
//   avg_valid  one-cycle pulse when avg_x/avg_y are updated
//   reject     one-cycle pulse when a fix is discarded as an outlier
//   locked     1 while tracking (window full)
//   fill       number of valid window entries, 0..DEPTH
module rfile_track_avg #(
    parameter int DEPTH       = 4,
    parameter int LOG2D       = 2,
    parameter int JUMP_TH     = 16,
    parameter int OUTLIER_MAX = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [7:0]       xt,
    input  logic [7:0]       yt,
    output logic [7:0]       avg_x,
    output logic [7:0]       avg_y,
    output logic             avg_valid,
    output logic             reject,
    output logic             locked,
    output logic [LOG2D:0]   fill
);

    localparam int SW  = 8 + LOG2D;                  // sums never overflow
    localparam int FW  = LOG2D + 1;
    localparam int OCW = $clog2(OUTLIER_MAX + 1);

    localparam logic [FW-1:0]  FILL_LAST = FW'(DEPTH - 1);
    localparam logic [OCW-1:0] OC_LAST   = OCW'(OUTLIER_MAX - 1);
    localparam logic [7:0]     JUMP_LIM  = 8'(JUMP_TH);
    localparam logic [SW:0]    HALF      = (SW + 1)'(DEPTH / 2);

    typedef enum logic {WARMUP, TRACK} state_t;

    state_t              state_reg, state_next;
    logic [7:0]          win_x_reg [DEPTH];
    logic [7:0]          win_y_reg [DEPTH];
    logic [LOG2D-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [SW-1:0]       sum_x_reg, sum_x_next;
    logic [SW-1:0]       sum_y_reg, sum_y_next;
    logic [FW-1:0]       fill_reg, fill_next;
    logic [OCW-1:0]      oc_reg, oc_next;
    logic                pub_pend_reg, pub_pend_next;
    logic                rej_pend_reg, rej_pend_next;
    logic [7:0]          avg_x_reg, avg_y_reg;
    logic                avg_valid_reg, reject_reg;

    logic                do_write;
    logic                do_relock;
    logic [7:0]          old_x, old_y;
    logic [7:0]          dev_x, dev_y;
    logic                jump;

    // Oldest entry is the one the pointer is about to overwrite.
    assign old_x = win_x_reg[wr_ptr_reg];
    assign old_y = win_y_reg[wr_ptr_reg];

    // Deviation is against the average currently published, even if a
    // newer one is about to be registered on this very edge.
    assign dev_x = (xt >= avg_x_reg) ? (xt - avg_x_reg) : (avg_x_reg - xt);
    assign dev_y = (yt >= avg_y_reg) ? (yt - avg_y_reg) : (avg_y_reg - yt);
    assign jump  = (dev_x > JUMP_LIM) || (dev_y > JUMP_LIM);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= WARMUP;
            wr_ptr_reg   <= '0;
            sum_x_reg    <= '0;
            sum_y_reg    <= '0;
            fill_reg     <= '0;
            oc_reg       <= '0;
            pub_pend_reg <= 1'b0;
            rej_pend_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wr_ptr_reg   <= wr_ptr_next;
            sum_x_reg    <= sum_x_next;
            sum_y_reg    <= sum_y_next;
            fill_reg     <= fill_next;
            oc_reg       <= oc_next;
            pub_pend_reg <= pub_pend_next;
            rej_pend_reg <= rej_pend_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and window control
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        wr_ptr_next   = wr_ptr_reg;
        sum_x_next    = sum_x_reg;
        sum_y_next    = sum_y_reg;
        fill_next     = fill_reg;
        oc_next       = oc_reg;
        pub_pend_next = 1'b0;
        rej_pend_next = 1'b0;
        do_write      = 1'b0;
        do_relock     = 1'b0;

        if (clear) begin
            state_next  = WARMUP;
            wr_ptr_next = '0;
            sum_x_next  = '0;
            sum_y_next  = '0;
            fill_next   = '0;
            oc_next     = '0;
        end else if (in_valid) begin
            case (state_reg)
                WARMUP: begin
                    do_write    = 1'b1;
                    wr_ptr_next = wr_ptr_reg + LOG2D'(1);
                    sum_x_next  = sum_x_reg + SW'(xt);
                    sum_y_next  = sum_y_reg + SW'(yt);
                    fill_next   = fill_reg + FW'(1);
                    if (fill_reg == FILL_LAST) begin
                        state_next    = TRACK;
                        pub_pend_next = 1'b1;
                    end
                end
                TRACK: begin
                    if (!jump) begin
                        do_write      = 1'b1;
                        wr_ptr_next   = wr_ptr_reg + LOG2D'(1);
                        // Modular arithmetic: the result is exact even if
                        // the intermediate would briefly go negative.
                        sum_x_next    = sum_x_reg + SW'(xt) - SW'(old_x);
                        sum_y_next    = sum_y_reg + SW'(yt) - SW'(old_y);
                        oc_next       = '0;
                        pub_pend_next = 1'b1;
                    end else begin
                        rej_pend_next = 1'b1;
                        if (oc_reg == OC_LAST) begin
                            // Too many outliers in a row: assume the target
                            // really moved and restart the window from here.
                            do_relock   = 1'b1;
                            state_next  = WARMUP;
                            wr_ptr_next = LOG2D'(1);
                            sum_x_next  = SW'(xt);
                            sum_y_next  = SW'(yt);
                            fill_next   = FW'(1);
                            oc_next     = '0;
                        end else begin
                            oc_next = oc_reg + OCW'(1);
                        end
                    end
                end
                default: state_next = WARMUP;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Window storage, one register pair per entry
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_win
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    win_x_reg[gi] <= '0;
                    win_y_reg[gi] <= '0;
                end else if (clear) begin
                    win_x_reg[gi] <= '0;
                    win_y_reg[gi] <= '0;
                end else if (do_relock) begin
                    win_x_reg[gi] <= (gi == 0) ? xt : 8'd0;
                    win_y_reg[gi] <= (gi == 0) ? yt : 8'd0;
                end else if (do_write && (wr_ptr_reg == LOG2D'(gi))) begin
                    win_x_reg[gi] <= xt;
                    win_y_reg[gi] <= yt;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output stage: publishes from the sums one cycle after the update
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            avg_x_reg     <= '0;
            avg_y_reg     <= '0;
            avg_valid_reg <= 1'b0;
            reject_reg    <= 1'b0;
        end else if (clear) begin
            avg_x_reg     <= '0;
            avg_y_reg     <= '0;
            avg_valid_reg <= 1'b0;
            reject_reg    <= 1'b0;
        end else begin
            avg_valid_reg <= pub_pend_reg;
            reject_reg    <= rej_pend_reg;
            if (pub_pend_reg) begin
                // Round half up; (255*DEPTH + DEPTH/2) >> LOG2D is 255.
                avg_x_reg <= 8'(({1'b0, sum_x_reg} + HALF) >> LOG2D);
                avg_y_reg <= 8'(({1'b0, sum_y_reg} + HALF) >> LOG2D);
            end
        end
    end

    assign avg_x     = avg_x_reg;
    assign avg_y     = avg_y_reg;
    assign avg_valid = avg_valid_reg;
    assign reject    = reject_reg;
    assign locked    = (state_reg == TRACK);
    assign fill      = fill_reg;

endmodule

// File: tb/tb_rfile_track_avg.sv
module tb_rfile_track_avg;

    localparam int DEPTH       = 4;
    localparam int LOG2D       = 2;
    localparam int JUMP_TH     = 16;
    localparam int OUTLIER_MAX = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           clear;
    logic           in_valid;
    logic [7:0]     xt;
    logic [7:0]     yt;
    logic [7:0]     avg_x;
    logic [7:0]     avg_y;
    logic           avg_valid;
    logic           reject;
    logic           locked;
    logic [LOG2D:0] fill;

    rfile_track_avg #(
        .DEPTH(DEPTH), .LOG2D(LOG2D), .JUMP_TH(JUMP_TH), .OUTLIER_MAX(OUTLIER_MAX)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .xt(xt), .yt(yt), .avg_x(avg_x), .avg_y(avg_y),
        .avg_valid(avg_valid), .reject(reject), .locked(locked), .fill(fill)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ------------------------------------------------------------------
    // Reference model: the window is a plain queue of the accepted fixes,
    // the average is the rounded arithmetic mean of that queue.
    // ------------------------------------------------------------------
    typedef struct {
        int x;
        int y;
    } fix_t;

    fix_t win_q[$];
    int   m_ax = 0, m_ay = 0, m_fill = 0, m_oc = 0;
    bit   m_vld = 0, m_rej = 0, m_lock = 0;
    bit   p_vld = 0, p_rej = 0;
    int   p_ax = 0, p_ay = 0;
    int   ox, oy, dx, dy;
    fix_t nf;

    function automatic int mean_axis(input bit use_y);
        int s = 0;
        foreach (win_q[i]) s += use_y ? win_q[i].y : win_q[i].x;
        return (s + DEPTH / 2) / DEPTH;
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                win_q.delete();
                m_ax = 0; m_ay = 0; m_fill = 0; m_oc = 0;
                m_vld = 0; m_rej = 0; m_lock = 0;
                p_vld = 0; p_rej = 0;
            end else begin
                ox = m_ax;
                oy = m_ay;
                m_vld = p_vld;
                m_rej = p_rej;
                if (p_vld) begin
                    m_ax = p_ax;
                    m_ay = p_ay;
                end
                p_vld = 0;
                p_rej = 0;
                nf.x = int'(xt);
                nf.y = int'(yt);
                if (clear) begin
                    win_q.delete();
                    m_ax = 0; m_ay = 0; m_vld = 0; m_rej = 0;
                    m_lock = 0; m_oc = 0;
                end else if (in_valid) begin
                    if (!m_lock) begin
                        win_q.push_back(nf);
                        if (win_q.size() == DEPTH) begin
                            m_lock = 1;
                            p_vld = 1;
                            p_ax = mean_axis(0);
                            p_ay = mean_axis(1);
                        end
                    end else begin
                        dx = nf.x - ox; if (dx < 0) dx = -dx;
                        dy = nf.y - oy; if (dy < 0) dy = -dy;
                        if (dx <= JUMP_TH && dy <= JUMP_TH) begin
                            void'(win_q.pop_front());
                            win_q.push_back(nf);
                            m_oc = 0;
                            p_vld = 1;
                            p_ax = mean_axis(0);
                            p_ay = mean_axis(1);
                        end else begin
                            p_rej = 1;
                            m_oc++;
                            if (m_oc == OUTLIER_MAX) begin
                                win_q.delete();
                                win_q.push_back(nf);
                                m_lock = 0;
                                m_oc = 0;
                            end
                        end
                    end
                end
                m_fill = win_q.size();
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                n_vec++;
                if (int'(avg_x) != m_ax || int'(avg_y) != m_ay || avg_valid != m_vld ||
                    reject != m_rej || locked != m_lock || int'(fill) != m_fill) begin
                    n_err++;
                    $display("FAIL cycle_model t=%0t: dut avg=(%0d,%0d) vld=%0b rej=%0b lock=%0b fill=%0d, model avg=(%0d,%0d) vld=%0b rej=%0b lock=%0b fill=%0d",
                             $time, avg_x, avg_y, avg_valid, reject, locked, fill,
                             m_ax, m_ay, m_vld, m_rej, m_lock, m_fill);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic send(input int x, input int y);
        @(posedge clk); #1;
        in_valid = 1'b1;
        xt = 8'(x);
        yt = 8'(y);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Two negedges after send(): first is just after the sampling edge,
    // second is just after the publishing edge.
    task automatic to_publish();
        @(negedge clk);
        @(negedge clk);
    endtask

    int vcount;

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; xt = '0; yt = '0;

        // 1. Reset state
        #3;
        chk("rst_avg_x", int'(avg_x), 0);
        chk("rst_avg_y", int'(avg_y), 0);
        chk("rst_valid", int'(avg_valid), 0);
        chk("rst_reject", int'(reject), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_fill", int'(fill), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 2. Warmup
        send(10, 20); idle(9);
        send(12, 22); idle(9);
        send(14, 24);
        @(negedge clk);
        chk("warm3_fill", int'(fill), 3);
        chk("warm3_locked", int'(locked), 0);
        idle(9);
        send(16, 26);
        @(negedge clk);
        chk("warm4_fill", int'(fill), 4);
        chk("warm4_locked", int'(locked), 1);
        chk("warm4_valid_early", int'(avg_valid), 0);
        @(negedge clk);
        chk("warm4_valid", int'(avg_valid), 1);
        chk("warm4_avg_x", int'(avg_x), 13);
        chk("warm4_avg_y", int'(avg_y), 23);
        @(negedge clk);
        chk("warm4_valid_drop", int'(avg_valid), 0);

        // 3. Sliding window: (18,28) replaces (10,20), sums (60,100)
        send(18, 28); to_publish();
        chk("slide_valid", int'(avg_valid), 1);
        chk("slide_avg_x", int'(avg_x), 15);
        chk("slide_avg_y", int'(avg_y), 25);

        // 4. Outliers and relock
        send(200, 200); to_publish();
        chk("out1_reject", int'(reject), 1);
        chk("out1_avg_x", int'(avg_x), 15);
        chk("out1_fill", int'(fill), 4);
        send(200, 200);
        send(200, 200);
        @(negedge clk);
        chk("relock_locked", int'(locked), 0);
        chk("relock_fill", int'(fill), 1);
        @(negedge clk);
        chk("relock_reject", int'(reject), 1);
        chk("relock_avg_hold", int'(avg_x), 15);
        send(200, 200); send(200, 200); send(200, 200); to_publish();
        chk("reacq_valid", int'(avg_valid), 1);
        chk("reacq_avg_x", int'(avg_x), 200);
        chk("reacq_avg_y", int'(avg_y), 200);
        chk("reacq_locked", int'(locked), 1);

        // Accepted fix between rejects resets the outlier run.
        send(10, 10); send(10, 10);
        send(205, 195); to_publish();
        chk("mid_accept_avg_x", int'(avg_x), 201);
        chk("mid_accept_avg_y", int'(avg_y), 199);
        send(10, 10); send(10, 10);
        @(negedge clk);
        chk("no_relock_locked", int'(locked), 1);
        chk("no_relock_fill", int'(fill), 4);
        send(10, 10);
        @(negedge clk);
        chk("relock2_fill", int'(fill), 1);

        // 5. clear with in_valid in the same cycle, mid-warmup (fill=2)
        send(50, 60);
        @(negedge clk);
        chk("pre_clear_fill", int'(fill), 2);
        @(posedge clk); #1;
        clear = 1'b1; in_valid = 1'b1; xt = 8'd99; yt = 8'd99;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("clear_fill", int'(fill), 0);
        chk("clear_avg_x", int'(avg_x), 0);
        chk("clear_avg_y", int'(avg_y), 0);
        chk("clear_locked", int'(locked), 0);
        @(negedge clk);
        chk("clear_valid", int'(avg_valid), 0);
        chk("clear_reject", int'(reject), 0);

        // 6. Back-to-back burst of (255,255) from reset
        @(posedge clk); #1 rst = 1'b1;
        idle(2); rst = 1'b0;
        vcount = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; xt = 8'd255; yt = 8'd255;
        repeat (8) begin
            @(negedge clk);
            if (avg_valid) vcount++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (avg_valid) vcount++;
        end
        // The 5th fix is checked against the average as it stands (still 0),
        // so it is rejected; publishes follow fixes 4, 6, 7 and 8.
        chk("burst_valid_count", vcount, 4);
        chk("burst_avg_x", int'(avg_x), 255);
        chk("burst_avg_y", int'(avg_y), 255);
        chk("burst_fill", int'(fill), 4);

        // Reset mid-burst
        @(posedge clk); #1;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("midrst_avg_x", int'(avg_x), 0);
        chk("midrst_avg_y", int'(avg_y), 0);
        chk("midrst_valid", int'(avg_valid), 0);
        chk("midrst_reject", int'(reject), 0);
        chk("midrst_locked", int'(locked), 0);
        chk("midrst_fill", int'(fill), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", int'(avg_valid), 0);
        @(negedge clk);
        chk("post_rst_valid2", int'(avg_valid), 0);
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
